// File: rtl/mult_client_pkg.sv
// mult_client_pkg
//   Shared definitions for the multiplier initiator (mult_client) and its
//   operand FIFO: FSM state encodings, data width and watchdog sizing.
//   No ports; imported with "import mult_client_pkg::*;".
package mult_client_pkg;

  localparam int DATA_W = 32;
  localparam int OPS_W  = 2 * DATA_W;

  // Watchdog sizing (used only when MULT_CLIENT_TIMEOUT_EN is defined).
  localparam int                WDOG_W     = 6;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 6'd63;
  // Counter value present during the last permitted WAIT cycle.
  localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_LIMIT - 6'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } stateT;

endpackage

// File: rtl/mult_client_fifo.sv
// mult_client_fifo
//   Synchronous DEPTH x WIDTH FIFO holding operand pairs {A, B}.
//   Pointers carry one extra MSB so full and empty are told apart when the
//   index bits match. The head entry is visible on headData without a pop.
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   synchronous, active-low
//   pushEn   in   write pushData (ignored while full)
//   pushData in   WIDTH-bit entry
//   popEn    in   drop head entry (ignored while empty)
//   headData out  current head entry
//   full     out  no free entries
//   empty    out  no stored entries
module mult_client_fifo
  import mult_client_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = OPS_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             pushEn,
  input  logic [WIDTH-1:0] pushData,
  input  logic             popEn,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wrPtr;
  logic [PTR_W:0]   rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPush   = pushEn && !full;
  assign doPop    = popEn && !empty;
  assign empty    = (wrPtr == rdPtr);
  // Same index but different wrap bit: writer is a full lap ahead.
  assign full     = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                    (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign headData = mem[rdPtr[PTR_W-1:0]];

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  // Storage needs no reset; stale entries are never visible while empty.
  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr[PTR_W-1:0]] <= pushData;
  end

endmodule

// File: rtl/mult_client.sv
// mult_client
//   Initiator for the 32-bit sequential multiplier (valid/idle/done/ack).
//   Operand pairs are queued in a FIFO, issued one at a time with operands
//   held stable until the product is captured, then the multiplier is
//   acknowledged and the product offered on a ready/valid result port.
//   Optional feature macro: MULT_CLIENT_TIMEOUT_EN adds a WAIT watchdog
//   that sets the sticky oTimeout flag and abandons a hung transaction.
// Ports:
//   Clock, Reset            clock; synchronous active-low reset
//   iOp_Valid/iOp_A/iOp_B   operand stream in; oOp_Ready = FIFO not full
//   oMul_A/oMul_B           operands to multiplier (held during compute)
//   oMul_Valid, oMul_Ack    one-cycle pulses to multiplier (Moore)
//   iMul_Idle, iMul_Done    multiplier status
//   iMul_Result             multiplier product (low 32 bits)
//   oRes_Valid/oRes_Data    result stream out; iRes_Ready from downstream
//   oBusy                   FIFO non-empty or FSM not IDLE
//   oTimeout                sticky watchdog flag (0 unless macro defined)
module mult_client
  import mult_client_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iOp_Valid,
  input  logic [DATA_W-1:0] iOp_A,
  input  logic [DATA_W-1:0] iOp_B,
  output logic              oOp_Ready,
  output logic [DATA_W-1:0] oMul_A,
  output logic [DATA_W-1:0] oMul_B,
  output logic              oMul_Valid,
  input  logic              iMul_Idle,
  input  logic              iMul_Done,
  input  logic [DATA_W-1:0] iMul_Result,
  output logic              oMul_Ack,
  output logic              oRes_Valid,
  output logic [DATA_W-1:0] oRes_Data,
  input  logic              iRes_Ready,
  output logic              oBusy,
  output logic              oTimeout
);

  stateT             state;
  stateT             nextState;
  logic [OPS_W-1:0]  fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              pushEn;
  logic              popEn;
  logic              capture;
  logic              timeoutHit;

  assign oOp_Ready = !fifoFull;
  assign pushEn    = iOp_Valid && oOp_Ready;
  // A stale DONE in IDLE takes priority over starting new work.
  assign popEn     = (state == IDLE) && !iMul_Done && !fifoEmpty && iMul_Idle;
  // Only capture when the result register is free; otherwise the
  // multiplier keeps DONE asserted and we simply stay in WAIT.
  assign capture   = (state == WAIT) && iMul_Done && !oRes_Valid;
  assign oBusy     = !fifoEmpty || (state != IDLE);

  mult_client_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OPS_W)
  ) uFifo (
    .Clock    (Clock),
    .Reset    (Reset),
    .pushEn   (pushEn),
    .pushData ({iOp_A, iOp_B}),
    .popEn    (popEn),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

`ifdef MULT_CLIENT_TIMEOUT_EN
  logic [WDOG_W-1:0] wdogCnt;

  // Counter sits at zero outside WAIT, so it restarts on every entry.
  // Cycles with DONE high (result backpressure) are not counted.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wdogCnt <= '0;
    end else if (state != WAIT) begin
      wdogCnt <= '0;
    end else if (!iMul_Done) begin
      wdogCnt <= wdogCnt + 6'd1;
    end
  end

  assign timeoutHit = (state == WAIT) && !iMul_Done && (wdogCnt == WDOG_LAST);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oTimeout <= 1'b0;
    end else if (timeoutHit) begin
      oTimeout <= 1'b1;
    end
  end
`else
  assign timeoutHit = 1'b0;
  assign oTimeout   = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (iMul_Done) begin
          nextState = ACK;
        end else if (popEn) begin
          nextState = ISSUE;
        end
      end
      ISSUE: nextState = WAIT;
      WAIT: begin
        if (capture) begin
          nextState = ACK;
        end else if (timeoutHit) begin
          nextState = IDLE;
        end
      end
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oMul_Valid = 1'b0;
    oMul_Ack   = 1'b0;
    case (state)
      ISSUE:   oMul_Valid = 1'b1;
      ACK:     oMul_Ack   = 1'b1;
      default: ;
    endcase
  end

  // Operand registers only change on a pop, so they stay put all through
  // ISSUE/WAIT/ACK.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oMul_A <= '0;
      oMul_B <= '0;
    end else if (popEn) begin
      oMul_A <= fifoHead[OPS_W-1:DATA_W];
      oMul_B <= fifoHead[DATA_W-1:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      oRes_Valid <= 1'b0;
      oRes_Data  <= '0;
    end else if (capture) begin
      oRes_Valid <= 1'b1;
      oRes_Data  <= iMul_Result;
    end else if (oRes_Valid && iRes_Ready) begin
      oRes_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_client.sv
// tb_mult_client
//   Self-checking bench for mult_client: a behavioural multiplier answers
//   the valid/idle/done/ack handshake with a 32-cycle compute; directed
//   operand vectors carry hand-computed products.
module tb_mult_client;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        iOp_Valid = 1'b0;
  logic [31:0] iOp_A = '0;
  logic [31:0] iOp_B = '0;
  logic        oOp_Ready;
  logic [31:0] oMul_A;
  logic [31:0] oMul_B;
  logic        oMul_Valid;
  logic        iMul_Idle;
  logic        iMul_Done;
  logic [31:0] iMul_Result;
  logic        oMul_Ack;
  logic        oRes_Valid;
  logic [31:0] oRes_Data;
  logic        iRes_Ready = 1'b1;
  logic        oBusy;
  logic        oTimeout;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  mult_client #(.DEPTH(4)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iOp_Valid   (iOp_Valid),
    .iOp_A       (iOp_A),
    .iOp_B       (iOp_B),
    .oOp_Ready   (oOp_Ready),
    .oMul_A      (oMul_A),
    .oMul_B      (oMul_B),
    .oMul_Valid  (oMul_Valid),
    .iMul_Idle   (iMul_Idle),
    .iMul_Done   (iMul_Done),
    .iMul_Result (iMul_Result),
    .oMul_Ack    (oMul_Ack),
    .oRes_Valid  (oRes_Valid),
    .oRes_Data   (oRes_Data),
    .iRes_Ready  (iRes_Ready),
    .oBusy       (oBusy),
    .oTimeout    (oTimeout)
  );

  // Multiplier model: 0 idle, 1 computing (32 cycles), 2 done until ack.
  // It is not reset by the DUT reset, so it can be left in DONE.
  int          mState = 0;
  int          mCnt = 0;
  logic [31:0] mProd = '0;
  bit          mulHold = 1'b0;
  bit          mulHang = 1'b0;

  assign iMul_Idle   = (mState == 0) && !mulHold;
  assign iMul_Done   = (mState == 2);
  assign iMul_Result = mProd;

  always @(posedge Clock) begin
    case (mState)
      0: if (oMul_Valid && !mulHang) begin
        mProd  <= oMul_A * oMul_B;
        mCnt   <= 0;
        mState <= 1;
      end
      1: if (mCnt == 31) mState <= 2;
         else mCnt <= mCnt + 1;
      2: if (oMul_Ack) mState <= 0;
      default: mState <= 0;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vecT;

  vecT vecs [7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    bit accepted;
    accepted = 1'b0;
    @(negedge Clock);
    iOp_Valid = 1'b1;
    iOp_A = a;
    iOp_B = b;
    for (int n = 0; n < 200; n++) begin
      if (oOp_Ready) begin
        @(posedge Clock);
        accepted = 1'b1;
        break;
      end
      @(negedge Clock);
    end
    #1 iOp_Valid = 1'b0;
    checkOutput("push_accept", {31'd0, accepted}, 32'd1);
  endtask

  task automatic waitResult(output logic [31:0] data, output bit got, input int budget);
    got = 1'b0;
    data = '0;
    for (int n = 0; n < budget; n++) begin
      @(negedge Clock);
      if (oRes_Valid) begin
        data = oRes_Data;
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int          validCyc, ackCyc, resCyc, validCnt, ackCnt, resSeen;
    logic [31:0] resData;
    bit          got, issued, stable;

    vecs[0] = '{32'd7,          32'd6,          32'd42};
    vecs[1] = '{32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
    vecs[2] = '{32'd0,          32'd12345,      32'd0};
    vecs[3] = '{32'h0001_0000,  32'h0001_0000,  32'd0};
    vecs[4] = '{32'd1234,       32'd5678,       32'd7006652};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
    vecs[6] = '{32'h1234_5678,  32'd16,         32'h2345_6780};

    // Reset state
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    checkOutput("rst_op_ready",  {31'd0, oOp_Ready},  32'd1);
    checkOutput("rst_busy",      {31'd0, oBusy},      32'd0);
    checkOutput("rst_mul_valid", {31'd0, oMul_Valid}, 32'd0);
    checkOutput("rst_mul_ack",   {31'd0, oMul_Ack},   32'd0);
    checkOutput("rst_res_valid", {31'd0, oRes_Valid}, 32'd0);
    checkOutput("rst_res_data",  oRes_Data,           32'd0);
    checkOutput("rst_mul_a",     oMul_A,              32'd0);
    checkOutput("rst_mul_b",     oMul_B,              32'd0);
    checkOutput("rst_timeout",   {31'd0, oTimeout},   32'd0);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Single op 7*6 with cycle-accurate handshake timing
    iOp_Valid = 1'b1;
    iOp_A = vecs[0].a;
    iOp_B = vecs[0].b;
    @(posedge Clock);
    #1 iOp_Valid = 1'b0;
    validCyc = -1; ackCyc = -1; resCyc = -1; validCnt = 0; ackCnt = 0;
    resData = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      if (oMul_Valid) begin
        validCnt++;
        if (validCyc < 0) validCyc = c;
      end
      if (oMul_Ack) begin
        ackCnt++;
        if (ackCyc < 0) ackCyc = c;
      end
      if (oRes_Valid && resCyc < 0) begin
        resCyc = c;
        resData = oRes_Data;
      end
    end
    checkOutput("t0_valid_cycle", validCyc, 32'd2);
    checkOutput("t0_valid_count", validCnt, 32'd1);
    checkOutput("t0_ack_cycle",   ackCyc,   32'd36);
    checkOutput("t0_ack_count",   ackCnt,   32'd1);
    checkOutput("t0_res_cycle",   resCyc,   32'd36);
    checkOutput("t0_res_data",    resData,  vecs[0].prod);
    checkOutput("t0_busy_end",    {31'd0, oBusy}, 32'd0);

    // Table of single ops: product and operand stability during compute
    for (int i = 1; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b);
      issued = 1'b0; stable = 1'b1; got = 1'b0; resData = '0;
      for (int n = 0; n < 80; n++) begin
        @(negedge Clock);
        if (oMul_Valid) issued = 1'b1;
        if (oRes_Valid) begin
          got = 1'b1;
          resData = oRes_Data;
          break;
        end
        if (issued && (oMul_A !== vecs[i].a || oMul_B !== vecs[i].b)) stable = 1'b0;
      end
      checkOutput($sformatf("vec%0d_got", i),    {31'd0, got},    32'd1);
      checkOutput($sformatf("vec%0d_prod", i),   resData,         vecs[i].prod);
      checkOutput($sformatf("vec%0d_stable", i), {31'd0, stable}, 32'd1);
    end
    repeat (3) @(negedge Clock);

    // Burst of 5 with the multiplier holding idle low: FIFO fills at 4
    mulHold = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i].a, vecs[i].b);
    @(negedge Clock);
    checkOutput("burst_full_ready", {31'd0, oOp_Ready}, 32'd0);
    checkOutput("burst_busy",       {31'd0, oBusy},     32'd1);
    repeat (3) @(negedge Clock);
    checkOutput("burst_hold_ready", {31'd0, oOp_Ready},  32'd0);
    checkOutput("burst_hold_issue", {31'd0, oMul_Valid}, 32'd0);
    mulHold = 1'b0;
    applyStimulus(vecs[4].a, vecs[4].b);
    for (int k = 0; k < 5; k++) begin
      waitResult(resData, got, 100);
      checkOutput($sformatf("burst%0d_got", k),  {31'd0, got}, 32'd1);
      checkOutput($sformatf("burst%0d_prod", k), resData,      vecs[k].prod);
    end
    repeat (5) @(negedge Clock);

    // Result backpressure across two ops
    iRes_Ready = 1'b0;
    applyStimulus(vecs[5].a, vecs[5].b);
    applyStimulus(vecs[6].a, vecs[6].b);
    validCnt = 0; ackCnt = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge Clock);
      if (oMul_Valid) validCnt++;
      if (oMul_Ack) ackCnt++;
    end
    checkOutput("bp_issue_count", validCnt, 32'd2);
    checkOutput("bp_ack_count",   ackCnt,   32'd1);
    checkOutput("bp_res_valid",   {31'd0, oRes_Valid}, 32'd1);
    checkOutput("bp_res_first",   oRes_Data, vecs[5].prod);
    checkOutput("bp_busy",        {31'd0, oBusy}, 32'd1);
    iRes_Ready = 1'b1;
    waitResult(resData, got, 20);
    checkOutput("bp_second_got",  {31'd0, got}, 32'd1);
    checkOutput("bp_second_prod", resData, vecs[6].prod);
    repeat (5) @(negedge Clock);

    // Reset during WAIT; multiplier finishes later and must be drained
    applyStimulus(vecs[1].a, vecs[1].b);
    issued = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      if (oMul_Valid) begin
        issued = 1'b1;
        break;
      end
    end
    checkOutput("mid_rst_issued", {31'd0, issued}, 32'd1);
    repeat (5) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    checkOutput("mid_rst_busy",      {31'd0, oBusy},      32'd0);
    checkOutput("mid_rst_res_valid", {31'd0, oRes_Valid}, 32'd0);
    checkOutput("mid_rst_mul_a",     oMul_A,              32'd0);
    Reset = 1'b1;
    ackCnt = 0; resSeen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge Clock);
      if (oMul_Ack) ackCnt++;
      if (oRes_Valid) resSeen++;
    end
    checkOutput("drain_ack_count", ackCnt,  32'd1);
    checkOutput("drain_res_seen",  resSeen, 32'd0);
    checkOutput("drain_mul_idle",  {31'd0, iMul_Idle}, 32'd1);
    checkOutput("drain_busy",      {31'd0, oBusy},     32'd0);

`ifdef MULT_CLIENT_TIMEOUT_EN
    // Multiplier never answers: watchdog fires after 63 WAIT cycles
    mulHang = 1'b1;
    applyStimulus(vecs[2].a, vecs[2].b);
    issued = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clock);
      if (oMul_Valid) begin
        issued = 1'b1;
        break;
      end
    end
    checkOutput("wd_issued", {31'd0, issued}, 32'd1);
    resCyc = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge Clock);
      if (oTimeout) begin
        resCyc = n;
        break;
      end
    end
    checkOutput("wd_timeout_cycle", resCyc, 32'd64);
    checkOutput("wd_idle_busy",     {31'd0, oBusy}, 32'd0);
    mulHang = 1'b0;
    applyStimulus(vecs[4].a, vecs[4].b);
    waitResult(resData, got, 80);
    checkOutput("wd_next_got",    {31'd0, got}, 32'd1);
    checkOutput("wd_next_prod",   resData, vecs[4].prod);
    checkOutput("wd_sticky",      {31'd0, oTimeout}, 32'd1);
`else
    checkOutput("no_wd_timeout", {31'd0, oTimeout}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
